// File: rtl/ase_hssi_loopback_emul.sv
// ----------------------------------------------------------------------------
// ase_hssi_loopback_emul
//
// Emulates NUM_CH independent HSSI Ethernet channels for AFU simulation.
// Each channel either loops its AXI-S TX stream back onto its RX stream through
// a small FIFO (LOOP mode) or silently accepts and discards TX traffic (SINK
// mode). Mode changes are only honoured between TX packets so a packet is never
// split across modes. Each channel also provides a hysteretic pause hint and
// saturating counters for looped and dropped packets.
//
// Parameters
//   NUM_CH    number of channels
//   DATA_W    tdata width per channel (tkeep is DATA_W/8)
//   DEPTH     loopback FIFO entries per channel (power of 2, >= 2)
//   PAUSE_HI  occupancy at/above which rx_pause is raised
//   PAUSE_LO  occupancy at/below which rx_pause is dropped
//   CNT_W     statistics counter width
//
// Ports (channel c uses slice c of every vector)
//   clk, rst_n                 clock, asynchronous active-low reset
//   loopback_en                mode request: 1 = loop, 0 = sink
//   tx_tvalid/tready/tdata/tkeep/tlast   AFU -> HSSI stream
//   rx_tvalid/tready/tdata/tkeep/tlast   HSSI -> AFU stream
//   rx_pause                   advisory flow-control hint toward the AFU
//   loop_pkt_cnt               packets delivered on RX (tlast beats popped)
//   drop_pkt_cnt               packets discarded in SINK mode
// ----------------------------------------------------------------------------
module ase_hssi_loopback_emul #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int PAUSE_HI = 12,
    parameter int PAUSE_LO = 4,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              loopback_en,

    input  logic [NUM_CH-1:0]              tx_tvalid,
    output logic [NUM_CH-1:0]              tx_tready,
    input  logic [NUM_CH*DATA_W-1:0]       tx_tdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   tx_tkeep,
    input  logic [NUM_CH-1:0]              tx_tlast,

    output logic [NUM_CH-1:0]              rx_tvalid,
    input  logic [NUM_CH-1:0]              rx_tready,
    output logic [NUM_CH*DATA_W-1:0]       rx_tdata,
    output logic [NUM_CH*(DATA_W/8)-1:0]   rx_tkeep,
    output logic [NUM_CH-1:0]              rx_tlast,

    output logic [NUM_CH-1:0]              rx_pause,
    output logic [NUM_CH*CNT_W-1:0]        loop_pkt_cnt,
    output logic [NUM_CH*CNT_W-1:0]        drop_pkt_cnt
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int OW     = AW + 1;
    // Stored beat layout: {tlast, tkeep, tdata}
    localparam int BEAT_W = DATA_W + KEEP_W + 1;

    localparam logic [OW-1:0] DEPTH_C    = OW'(DEPTH);
    localparam logic [OW-1:0] PAUSE_HI_C = OW'(PAUSE_HI);
    localparam logic [OW-1:0] PAUSE_LO_C = OW'(PAUSE_LO);

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("ase_hssi_loopback_emul: DEPTH must be a power of 2 and >= 2");
    end
    if (PAUSE_LO < 0 || PAUSE_LO >= PAUSE_HI || PAUSE_HI > DEPTH) begin : gBadPause
        $error("ase_hssi_loopback_emul: need 0 <= PAUSE_LO < PAUSE_HI <= DEPTH");
    end

    typedef enum logic {
        SINK = 1'b0,
        LOOP = 1'b1
    } mode_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gCh
            mode_t             modeReg;
            mode_t             modeNext;
            logic              midPktReg;
            logic              midPktNext;
            logic [AW-1:0]     wrPtrReg;
            logic [AW-1:0]     rdPtrReg;
            logic [OW-1:0]     occReg;
            logic [OW-1:0]     occNext;
            logic              pauseReg;
            logic [CNT_W-1:0]  loopCntReg;
            logic [CNT_W-1:0]  dropCntReg;

            // Loopback storage; read combinationally so a beat written at one
            // edge is visible on RX right after that edge.
            logic [BEAT_W-1:0] fifoMem [DEPTH];

            logic              full;
            logic              empty;
            logic              txReady;
            logic              txAccept;
            logic              push;
            logic              pop;
            logic              sinkLast;
            logic              popLast;
            logic [BEAT_W-1:0] txBeat;
            logic [BEAT_W-1:0] rxBeat;

            assign txBeat = {tx_tlast[gi],
                             tx_tkeep[gi*KEEP_W +: KEEP_W],
                             tx_tdata[gi*DATA_W +: DATA_W]};

            assign full  = (occReg == DEPTH_C);
            assign empty = (occReg == '0);

            // SINK always accepts; LOOP back-pressures only on a full FIFO.
            // Pause never gates tx_tready.
            assign txReady  = (modeReg == SINK) || !full;
            assign txAccept = tx_tvalid[gi] && txReady;
            assign push     = txAccept && (modeReg == LOOP);
            assign sinkLast = txAccept && (modeReg == SINK) && tx_tlast[gi];

            // RX drains in both modes so residue empties after LOOP -> SINK.
            assign rxBeat  = fifoMem[rdPtrReg];
            assign pop     = !empty && rx_tready[gi];
            assign popLast = pop && rxBeat[BEAT_W-1];

            always_comb begin
                occNext = occReg;
                if (push && !pop) begin
                    occNext = occReg + 1'b1;
                end else if (!push && pop) begin
                    occNext = occReg - 1'b1;
                end
            end

            always_comb begin
                midPktNext = midPktReg;
                if (txAccept) begin
                    midPktNext = !tx_tlast[gi];
                end
            end

            // The request is sampled whenever no packet will be open after this
            // edge. This covers idle cycles and the edge accepting a tlast beat,
            // but not the edge accepting a packet's first (non-last) beat, which
            // must be handled entirely by the mode already in force.
            always_comb begin
                modeNext = modeReg;
                if (!midPktNext) begin
                    modeNext = loopback_en[gi] ? LOOP : SINK;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    modeReg    <= SINK;
                    midPktReg  <= 1'b0;
                    wrPtrReg   <= '0;
                    rdPtrReg   <= '0;
                    occReg     <= '0;
                    pauseReg   <= 1'b0;
                    loopCntReg <= '0;
                    dropCntReg <= '0;
                end else begin
                    modeReg   <= modeNext;
                    midPktReg <= midPktNext;
                    occReg    <= occNext;

                    // Pointers wrap naturally since DEPTH is a power of 2
                    if (push) begin
                        wrPtrReg <= wrPtrReg + 1'b1;
                    end
                    if (pop) begin
                        rdPtrReg <= rdPtrReg + 1'b1;
                    end

                    // Hysteresis on the post-edge occupancy
                    if (occNext >= PAUSE_HI_C) begin
                        pauseReg <= 1'b1;
                    end else if (occNext <= PAUSE_LO_C) begin
                        pauseReg <= 1'b0;
                    end

                    if (popLast && (loopCntReg != '1)) begin
                        loopCntReg <= loopCntReg + 1'b1;
                    end
                    if (sinkLast && (dropCntReg != '1)) begin
                        dropCntReg <= dropCntReg + 1'b1;
                    end
                end
            end

            // Storage has no reset: occupancy and pointers define validity
            always_ff @(posedge clk) begin
                if (push) begin
                    fifoMem[wrPtrReg] <= txBeat;
                end
            end

            assign tx_tready[gi]                   = txReady;
            assign rx_tvalid[gi]                   = !empty;
            assign rx_tdata[gi*DATA_W +: DATA_W]   = rxBeat[DATA_W-1:0];
            assign rx_tkeep[gi*KEEP_W +: KEEP_W]   = rxBeat[DATA_W +: KEEP_W];
            assign rx_tlast[gi]                    = rxBeat[BEAT_W-1];
            assign rx_pause[gi]                    = pauseReg;
            assign loop_pkt_cnt[gi*CNT_W +: CNT_W] = loopCntReg;
            assign drop_pkt_cnt[gi*CNT_W +: CNT_W] = dropCntReg;
        end
    endgenerate

endmodule

// File: tb/tb_ase_hssi_loopback_emul.sv
// ----------------------------------------------------------------------------
// Directed bench for ase_hssi_loopback_emul: a default 4-channel instance plus
// a 1-channel CNT_W=4 instance for counter saturation.
// ----------------------------------------------------------------------------
module tb_ase_hssi_loopback_emul;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NCH-1:0]      loopback_en;
    logic [NCH-1:0]      tx_tvalid, tx_tready, tx_tlast;
    logic [NCH*DW-1:0]   tx_tdata;
    logic [NCH*KW-1:0]   tx_tkeep;
    logic [NCH-1:0]      rx_tvalid, rx_tready, rx_tlast, rx_pause;
    logic [NCH*DW-1:0]   rx_tdata;
    logic [NCH*KW-1:0]   rx_tkeep;
    logic [NCH*16-1:0]   loop_pkt_cnt, drop_pkt_cnt;

    logic        sLoopEn, sTxValid, sTxReady, sTxLast;
    logic [63:0] sTxData, sRxData;
    logic [7:0]  sTxKeep, sRxKeep;
    logic        sRxValid, sRxReady, sRxLast, sRxPause;
    logic [3:0]  sLoopCnt, sDropCnt;

    ase_hssi_loopback_emul dut (
        .clk(clk), .rst_n(rst_n), .loopback_en(loopback_en),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .rx_pause(rx_pause), .loop_pkt_cnt(loop_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
    );

    ase_hssi_loopback_emul #(.NUM_CH(1), .CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .loopback_en(sLoopEn),
        .tx_tvalid(sTxValid), .tx_tready(sTxReady), .tx_tdata(sTxData),
        .tx_tkeep(sTxKeep), .tx_tlast(sTxLast),
        .rx_tvalid(sRxValid), .rx_tready(sRxReady), .rx_tdata(sRxData),
        .rx_tkeep(sRxKeep), .rx_tlast(sRxLast),
        .rx_pause(sRxPause), .loop_pkt_cnt(sLoopCnt), .drop_pkt_cnt(sDropCnt)
    );

    int passCnt  = 0;
    int totalCnt = 0;

    // Per-channel scoreboard of {tlast, tkeep, tdata}
    logic [72:0] sb [NCH][$];
    int          seqNum [NCH];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalCnt = totalCnt + 1;
        assert (obs === exp) passCnt = passCnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBeat(input int c, input logic [63:0] d, input logic last);
        tx_tvalid[c]          = 1'b1;
        tx_tdata[c*DW +: DW]  = d;
        tx_tkeep[c*KW +: KW]  = 8'hFF;
        tx_tlast[c]           = last;
    endtask

    // Called between edges, where all DUT outputs depend only on state:
    // record accepted TX beats, check popped RX beats against the scoreboard.
    task automatic sbStep();
        for (int c = 0; c < NCH; c++) begin
            if (tx_tvalid[c] && tx_tready[c]) begin
                sb[c].push_back({tx_tlast[c], tx_tkeep[c*KW +: KW], tx_tdata[c*DW +: DW]});
            end
            if (rx_tvalid[c] && rx_tready[c]) begin
                if (sb[c].size() != 0) begin
                    chk($sformatf("rand ch%0d beat", c),
                        {rx_tlast[c], rx_tkeep[c*KW +: KW], rx_tdata[c*DW +: DW]}, sb[c][0]);
                    void'(sb[c].pop_front());
                end else begin
                    chk($sformatf("rand ch%0d spurious", c), rx_tvalid[c], 1'b0);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        loopback_en = '0; tx_tvalid = '0; tx_tlast = '0; tx_tdata = '0; tx_tkeep = '0;
        rx_tready = '0;
        sLoopEn = 1'b0; sTxValid = 1'b0; sTxLast = 1'b0; sTxData = '0; sTxKeep = '0;
        sRxReady = 1'b0;
        for (int c = 0; c < NCH; c++) seqNum[c] = 0;

        tick(); tick();
        chk("reset tx_tready", tx_tready, 4'hF);
        chk("reset rx_tvalid", rx_tvalid, 4'h0);
        chk("reset rx_pause", rx_pause, 4'h0);
        chk("reset loop_cnt", loop_pkt_cnt, 64'h0);
        chk("reset drop_cnt", drop_pkt_cnt, 64'h0);
        rst_n = 1'b1;

        // Channel 0: 3-beat loop, 1-cycle latency
        loopback_en[0] = 1'b1;
        tick();
        chk("ch0 tready loop", tx_tready[0], 1'b1);
        chk("ch0 idle rx_tvalid", rx_tvalid[0], 1'b0);
        setBeat(0, 64'h11, 1'b0); tick();
        chk("ch0 b0 valid", rx_tvalid[0], 1'b1);
        chk("ch0 b0 data", rx_tdata[63:0], 64'h11);
        rx_tready[0] = 1'b1;
        setBeat(0, 64'h22, 1'b0); tick();
        chk("ch0 b1 data", rx_tdata[63:0], 64'h22);
        chk("ch0 b1 last", rx_tlast[0], 1'b0);
        setBeat(0, 64'h33, 1'b1); tick();
        chk("ch0 b2 data", rx_tdata[63:0], 64'h33);
        chk("ch0 b2 last", rx_tlast[0], 1'b1);
        chk("ch0 b2 keep", rx_tkeep[7:0], 8'hFF);
        tx_tvalid[0] = 1'b0; tick();
        chk("ch0 drained", rx_tvalid[0], 1'b0);
        chk("ch0 loop_cnt", loop_pkt_cnt[15:0], 16'd1);

        // Channel 1: fill to full, pause hysteresis
        loopback_en[1] = 1'b1; rx_tready[1] = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            setBeat(1, 64'(i), (i == 15));
            tick();
            if (i == 10) chk("ch1 pause at 11", rx_pause[1], 1'b0);
            if (i == 11) chk("ch1 pause at 12", rx_pause[1], 1'b1);
        end
        chk("ch1 full tready", tx_tready[1], 1'b0);
        setBeat(1, 64'hAA, 1'b0); tick();
        tx_tvalid[1] = 1'b0;
        chk("ch1 still full", tx_tready[1], 1'b0);
        chk("ch1 head data", rx_tdata[127:64], 64'h0);
        rx_tready[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("ch1 drain %0d", j), rx_tdata[127:64], 64'(j));
            tick();
            if (j == 10) chk("ch1 pause at 5", rx_pause[1], 1'b1);
            if (j == 11) chk("ch1 pause at 4", rx_pause[1], 1'b0);
        end
        chk("ch1 empty", rx_tvalid[1], 1'b0);
        chk("ch1 loop_cnt", loop_pkt_cnt[31:16], 16'd1);

        // Channel 2: mode drop mid-packet takes effect after tlast
        loopback_en[2] = 1'b1; rx_tready[2] = 1'b0;
        tick();
        setBeat(2, 64'hA0, 1'b0); tick();
        setBeat(2, 64'hA1, 1'b0); tick();
        loopback_en[2] = 1'b0;
        setBeat(2, 64'hA2, 1'b0); tick();
        setBeat(2, 64'hA3, 1'b1); tick();
        setBeat(2, 64'hB0, 1'b0); tick();
        setBeat(2, 64'hB1, 1'b1); tick();
        tx_tvalid[2] = 1'b0;
        chk("ch2 sink tready", tx_tready[2], 1'b1);
        chk("ch2 drop_cnt", drop_pkt_cnt[47:32], 16'd1);
        chk("ch2 loop_cnt pre", loop_pkt_cnt[47:32], 16'd0);
        rx_tready[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch2 residue %0d", k), {rx_tvalid[2], rx_tlast[2], rx_tdata[191:128]},
                {1'b1, (k == 3), 64'hA0 + 64'(k)});
            tick();
        end
        chk("ch2 empty", rx_tvalid[2], 1'b0);
        chk("ch2 loop_cnt", loop_pkt_cnt[47:32], 16'd1);

        // Saturation on the CNT_W=4 instance: 20 one-beat packets
        sLoopEn = 1'b1; sRxReady = 1'b1;
        tick();
        for (int n = 0; n < 20; n++) begin
            sTxValid = 1'b1; sTxData = 64'(n); sTxKeep = 8'h0F; sTxLast = 1'b1;
            tick();
        end
        sTxValid = 1'b0; tick();
        chk("sat loop_cnt", sLoopCnt, 4'd15);
        chk("sat drained", sRxValid, 1'b0);

        // Channel 3: asynchronous reset with 5 beats queued mid-packet
        loopback_en[3] = 1'b1; rx_tready[3] = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            setBeat(3, 64'hC0 + 64'(n), 1'b0);
            tick();
        end
        tx_tvalid[3] = 1'b0;
        chk("ch3 queued", rx_tvalid[3], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rx_tvalid", rx_tvalid, 4'h0);
        chk("async rst loop_cnt", loop_pkt_cnt, 64'h0);
        chk("async rst drop_cnt", drop_pkt_cnt, 64'h0);
        chk("async rst tx_tready", tx_tready, 4'hF);
        chk("async rst sat cnt", sLoopCnt, 4'd0);
        tick();
        rst_n = 1'b1;
        rx_tready = 4'hF;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("ch3 post-rst idle %0d", n), rx_tvalid[3], 1'b0);
        end

        // All channels looping with random back-pressure
        loopback_en = 4'hF; tx_tvalid = '0; rx_tready = '0;
        tick();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                rx_tready[c]         = 1'($urandom_range(0, 1));
                tx_tvalid[c]         = 1'($urandom_range(0, 1));
                tx_tdata[c*DW +: DW] = {8'(c), 24'h0, 32'(seqNum[c])};
                tx_tkeep[c*KW +: KW] = 8'($urandom_range(0, 255));
                tx_tlast[c]          = 1'($urandom_range(0, 1));
                if (tx_tvalid[c] && tx_tready[c]) seqNum[c] = seqNum[c] + 1;
            end
            sbStep();
            tick();
        end
        tx_tvalid = '0; rx_tready = 4'hF;
        for (int cyc = 0; cyc < 20; cyc++) begin
            sbStep();
            tick();
        end
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rand ch%0d leftover", c), sb[c].size(), 0);
        end
        chk("rand all drained", rx_tvalid, 4'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/ase_hssi_loopback_emul.md
ASE_HSSI_LOOPBACK_EMUL -- requirements
Module: ase_hssi_loopback_emul

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent Ethernet channels emulated.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the AXI-S tdata width per channel; tkeep width is DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 16, meaning loopback FIFO entries per channel; it is a power of 2 and at least 2.
REQ-004 SHALL have parameters PAUSE_HI, default 12, and PAUSE_LO, default 4, meaning the pause assert/deassert fill levels; 0 <= PAUSE_LO < PAUSE_HI <= DEPTH, enforced by an elaboration-time check.
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-006 clk  in  1  single clock for all channels.
REQ-007 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 loopback_en  in  NUM_CH  per-channel mode request: 1 = loop TX to RX, 0 = sink TX.
REQ-009 tx_tvalid / tx_tready  in / out  NUM_CH each  AFU-to-HSSI handshake.
REQ-010 tx_tdata / tx_tkeep / tx_tlast  in  NUM_CH*DATA_W / NUM_CH*DATA_W/8 / NUM_CH  TX beat payload.
REQ-011 rx_tvalid / rx_tready  out / in  NUM_CH each  HSSI-to-AFU handshake.
REQ-012 rx_tdata / rx_tkeep / rx_tlast  out  same widths as TX  RX beat payload.
REQ-013 rx_pause  out  NUM_CH  per-channel pause flow-control indication toward the AFU.
REQ-014 loop_pkt_cnt / drop_pkt_cnt  out  NUM_CH*CNT_W each  per-channel count of looped and discarded packets.

Function
REQ-015 Each channel SHALL be fully independent; channel c occupies slice c of every vector.
REQ-016 Each channel SHALL hold a two-state mode FSM, SINK and LOOP; the reset state is SINK.
REQ-017 The FSM SHALL change mode only at a TX packet boundary: it samples loopback_en when the TX side is not mid-packet. Mid-packet means a beat with tlast=0 has been accepted and no tlast beat has been accepted since.
REQ-018 A request change arriving mid-packet SHALL take effect in the cycle after the tlast beat is accepted.
REQ-019 In SINK mode, tx_tready SHALL be 1 and accepted beats SHALL be discarded.
REQ-020 In LOOP mode, tx_tready SHALL equal !full, and an accepted beat (tvalid & tready) SHALL be written to the FIFO with its tdata, tkeep and tlast.
REQ-021 A beat accepted at edge N SHALL appear on rx_tvalid and rx_t* after edge N; the minimum TX-to-RX latency is 1 cycle.
REQ-022 rx_tvalid SHALL equal !empty in both modes, so FIFO contents drain after a LOOP-to-SINK switch.
REQ-023 rx_t* SHALL be held stable while rx_tvalid=1 and rx_tready=0.
REQ-024 The FIFO SHALL pop on rx_tvalid & rx_tready.
REQ-025 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-026 Because tx_tready=!full, a push while full is impossible, even when a pop occurs in the same cycle.
REQ-027 The occupancy counter SHALL be $clog2(DEPTH)+1 bits wide, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-028 rx_pause SHALL be registered with hysteresis:
- set when the next occupancy >= PAUSE_HI;
- cleared when the next occupancy <= PAUSE_LO;
- otherwise held.
REQ-029 loop_pkt_cnt SHALL increment on each popped beat with tlast=1.
REQ-030 drop_pkt_cnt SHALL increment on each SINK-mode accepted beat with tlast=1.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1.
REQ-032 Pause state SHALL not alter tx_tready; pause is advisory only.

Reset
REQ-033 While rst_n=0, the block SHALL hold the following values:
- FSM = SINK and mid-packet flag = 0;
- FIFO empty and pointers = 0;
- rx_tvalid = 0 and rx_pause = 0;
- both counters = 0;
- tx_tready = 1.
REQ-034 Reset asserted mid-packet SHALL discard all FIFO contents and partial packets with no further output beats.
REQ-035 After rst_n deasserts, the first loopback_en sample SHALL occur on the first clk edge.

Verification
REQ-036 Channel 0, loopback_en=1, 3-beat packet (data 0x11, 0x22, 0x33; tlast on 0x33), rx_tready=1 -> the same 3 beats in order on RX, first one cycle after acceptance; loop_pkt_cnt[0]=1.
REQ-037 Channel 1, loopback_en=1, rx_tready=0, 16 beats offered -> 16 accepted, then tx_tready=0; rx_pause set at occupancy 12; after releasing rx_tready, rx_pause clears at occupancy 4.
REQ-038 Channel 2, loopback_en dropped to 0 after beat 1 of a 4-beat packet -> all 4 beats are looped; the next packet is sunk with tx_tready=1 and drop_pkt_cnt[2]=1; FIFO residue still drains.
REQ-039 CNT_W=4, 20 one-beat packets looped -> loop_pkt_cnt stays at 15.
REQ-040 rst_n pulsed low with 5 beats queued -> rx_tvalid=0 immediately (asynchronously), counters=0, and no queued beats appear after release.
REQ-041 All 4 channels looping concurrently with random rx_tready -> per-channel data matches the scoreboard, with no cross-channel leakage.
